alu_issue_unit: RTL and testbench

- Initiator side of the 32-bit ALU interface (a, b, 3-bit ctrl -> out).
- Accepts one RV32I OP or OP-IMM instruction with its rs1/rs2 values over a valid/ready handshake.
- Decodes it into ALU operands and ctrl, drives the ALU, captures the result and returns it over a valid/ready response channel.
- Sits between register-read and writeback in the multi-cycle RV32I core.

---
 rtl/alu_issue_unit.sv | 169 ++++++++++++++++
 tb/tb_alu_issue_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_unit.sv
// Decodes one RV32I OP/OP-IMM request, drives the external ALU for EXEC_CYCLES, returns the result.
// One request in flight; in_ready only in IDLE; the response is held until out_ready.
module alu_issue_unit #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_err
);

  localparam int CW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(EXEC_CYCLES - 1);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_AND = 3'b010;
  localparam logic [2:0] CTRL_OR  = 3'b011;
  localparam logic [2:0] CTRL_XOR = 3'b100;
  localparam logic [2:0] CTRL_SLL = 3'b101;
  localparam logic [2:0] CTRL_SRL = 3'b110;
  localparam logic [2:0] CTRL_SRA = 3'b111;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [31:0] imm, shamt_imm, shamt_reg;
  logic        dec_legal;
  logic [2:0]  dec_ctrl;
  logic [31:0] dec_b;
  logic        unused_instr_bits;

  assign opcode    = in_instr[6:0];
  assign f3        = in_instr[14:12];
  assign f7        = in_instr[31:25];
  assign imm       = {{20{in_instr[31]}}, in_instr[31:20]};
  assign shamt_imm = {27'b0, in_instr[24:20]};
  assign shamt_reg = {27'b0, in_rs2[4:0]};
  // rs1 index is resolved by register-read; only its value arrives here.
  assign unused_instr_bits = ^in_instr[19:15];

  always_comb begin
    dec_legal = 1'b0;
    dec_ctrl  = CTRL_ADD;
    dec_b     = in_rs2;
    case (opcode)
      OPC_OP: begin
        if (f7 == F7_ZERO) begin
          dec_legal = 1'b1;
          case (f3)
            3'b000: dec_ctrl = CTRL_ADD;
            3'b001: begin dec_ctrl = CTRL_SLL; dec_b = shamt_reg; end
            3'b100: dec_ctrl = CTRL_XOR;
            3'b101: begin dec_ctrl = CTRL_SRL; dec_b = shamt_reg; end
            3'b110: dec_ctrl = CTRL_OR;
            3'b111: dec_ctrl = CTRL_AND;
            default: dec_legal = 1'b0;
          endcase
        end else if (f7 == F7_ALT) begin
          case (f3)
            3'b000: begin dec_legal = 1'b1; dec_ctrl = CTRL_SUB; end
            3'b101: begin dec_legal = 1'b1; dec_ctrl = CTRL_SRA; dec_b = shamt_reg; end
            default: dec_legal = 1'b0;
          endcase
        end
      end
      OPC_OP_IMM: begin
        dec_b = imm;
        case (f3)
          3'b000: begin dec_legal = 1'b1; dec_ctrl = CTRL_ADD; end
          3'b100: begin dec_legal = 1'b1; dec_ctrl = CTRL_XOR; end
          3'b110: begin dec_legal = 1'b1; dec_ctrl = CTRL_OR;  end
          3'b111: begin dec_legal = 1'b1; dec_ctrl = CTRL_AND; end
          3'b001: begin
            dec_legal = (f7 == F7_ZERO);
            dec_ctrl  = CTRL_SLL;
            dec_b     = shamt_imm;
          end
          3'b101: begin
            dec_legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
            dec_ctrl  = (f7 == F7_ALT) ? CTRL_SRA : CTRL_SRL;
            dec_b     = shamt_imm;
          end
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = dec_legal ? EXEC : RESP;
      EXEC: if (cnt == '0) state_nxt = RESP;
      RESP: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      out_result <= '0;
      out_rd     <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_rd <= in_instr[11:7];
            if (dec_legal) begin
              alu_a    <= in_rs1;
              alu_b    <= dec_b;
              alu_ctrl <= dec_ctrl;
              cnt      <= CNT_INIT;
            end else begin
              // Illegal ops never touch the ALU operands.
              out_err    <= 1'b1;
              out_result <= '0;
            end
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            out_result <= alu_out;
            out_err    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: two instances (EXEC_CYCLES 1 and 3) checked every cycle against a
// transaction-level model, plus directed literal checks and randomized traffic.
module tb_alu_issue_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_instr  [2];
  logic [31:0] in_rs1    [2];
  logic [31:0] in_rs2    [2];
  logic [31:0] alu_a     [2];
  logic [31:0] alu_b     [2];
  logic [2:0]  alu_ctrl  [2];
  logic [31:0] alu_out   [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_result[2];
  logic [4:0]  out_rd    [2];
  logic        out_err   [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    case (c)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b;
      3'd6: return a >> b;
      default: return $unsigned($signed(a) >>> b);
    endcase
  endfunction

  assign alu_out[0] = alu_f(alu_a[0], alu_b[0], alu_ctrl[0]);
  assign alu_out[1] = alu_f(alu_a[1], alu_b[1], alu_ctrl[1]);

  alu_issue_unit #(.EXEC_CYCLES(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_instr(in_instr[0]), .in_rs1(in_rs1[0]), .in_rs2(in_rs2[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_ctrl(alu_ctrl[0]), .alu_out(alu_out[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_result(out_result[0]),
    .out_rd(out_rd[0]), .out_err(out_err[0])
  );

  alu_issue_unit #(.EXEC_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_instr(in_instr[1]), .in_rs1(in_rs1[1]), .in_rs2(in_rs2[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_ctrl(alu_ctrl[1]), .alu_out(alu_out[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_result(out_result[1]),
    .out_rd(out_rd[1]), .out_err(out_err[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Instruction semantics: expected legality, ALU drive and architectural result.
  function automatic void ref_op(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                                 output bit legal, output logic [2:0] c, output logic [31:0] b,
                                 output logic [31:0] res);
    logic [31:0] imm;
    logic [4:0]  sh;
    imm   = {{20{ins[31]}}, ins[31:20]};
    sh    = ins[24:20];
    legal = 1'b1;
    c     = 3'd0;
    b     = r2;
    res   = 32'd0;
    casez ({ins[6:0], ins[14:12], ins[31:25]})
      17'b0110011_000_0000000: begin c = 3'd0; res = r1 + r2; end
      17'b0110011_000_0100000: begin c = 3'd1; res = r1 - r2; end
      17'b0110011_001_0000000: begin c = 3'd5; b = {27'b0, r2[4:0]}; res = r1 << r2[4:0]; end
      17'b0110011_100_0000000: begin c = 3'd4; res = r1 ^ r2; end
      17'b0110011_101_0000000: begin c = 3'd6; b = {27'b0, r2[4:0]}; res = r1 >> r2[4:0]; end
      17'b0110011_101_0100000: begin c = 3'd7; b = {27'b0, r2[4:0]}; res = $unsigned($signed(r1) >>> r2[4:0]); end
      17'b0110011_110_0000000: begin c = 3'd3; res = r1 | r2; end
      17'b0110011_111_0000000: begin c = 3'd2; res = r1 & r2; end
      17'b0010011_000_???????: begin c = 3'd0; b = imm; res = r1 + imm; end
      17'b0010011_100_???????: begin c = 3'd4; b = imm; res = r1 ^ imm; end
      17'b0010011_110_???????: begin c = 3'd3; b = imm; res = r1 | imm; end
      17'b0010011_111_???????: begin c = 3'd2; b = imm; res = r1 & imm; end
      17'b0010011_001_0000000: begin c = 3'd5; b = {27'b0, sh}; res = r1 << sh; end
      17'b0010011_101_0000000: begin c = 3'd6; b = {27'b0, sh}; res = r1 >> sh; end
      17'b0010011_101_0100000: begin c = 3'd7; b = {27'b0, sh}; res = $unsigned($signed(r1) >>> sh); end
      default: legal = 1'b0;
    endcase
  endfunction

  // Transaction-level model: one outstanding request per instance, timed by edge counts.
  int          e = 0;
  bit          m_act  [2];
  int          m_acc  [2];
  int          m_lat  [2];
  bit          m_legal[2];
  logic [31:0] m_res  [2];
  logic [4:0]  m_rd   [2];
  logic [31:0] m_a    [2];
  logic [31:0] m_b    [2];
  logic [2:0]  m_c    [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_act[k] <= 1'b0;
        m_a[k]   <= '0;
        m_b[k]   <= '0;
        m_c[k]   <= '0;
      end
    end else begin
      e <= e + 1;
      for (int k = 0; k < 2; k++) begin
        if (m_act[k]) begin
          if ((e - m_acc[k] >= m_lat[k]) && out_ready[k]) m_act[k] <= 1'b0;
        end else if (in_valid[k]) begin
          bit          lg;
          logic [2:0]  c;
          logic [31:0] b, r;
          ref_op(in_instr[k], in_rs1[k], in_rs2[k], lg, c, b, r);
          m_act[k]   <= 1'b1;
          m_acc[k]   <= e + 1;
          m_lat[k]   <= lg ? ((k == 0) ? 1 : 3) : 0;
          m_legal[k] <= lg;
          m_res[k]   <= r;
          m_rd[k]    <= in_instr[k][11:7];
          if (lg) begin
            m_a[k] <= in_rs1[k];
            m_b[k] <= b;
            m_c[k] <= c;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("in_ready", k, in_ready[k], !m_act[k]);
      chk("out_valid", k, out_valid[k], m_act[k] && (e - m_acc[k] >= m_lat[k]));
      chk("alu_a", k, alu_a[k], m_a[k]);
      chk("alu_b", k, alu_b[k], m_b[k]);
      chk("alu_ctrl", k, alu_ctrl[k], m_c[k]);
      if (m_act[k] && (e - m_acc[k] >= m_lat[k])) begin
        chk("out_result", k, out_result[k], m_res[k]);
        chk("out_rd", k, out_rd[k], m_rd[k]);
        chk("out_err", k, out_err[k], !m_legal[k]);
      end
      if (!rst_n) begin
        chk("rst_out_result", k, out_result[k], 32'd0);
        chk("rst_out_rd", k, out_rd[k], 5'd0);
        chk("rst_out_err", k, out_err[k], 1'b0);
      end
    end
  end

  task automatic req(input int k, input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                     input int hold, output logic [31:0] res, output logic err, output logic [4:0] rd,
                     output int lat, output logic [31:0] a, output logic [31:0] b, output logic [2:0] c);
    in_valid[k] = 1'b1;
    in_instr[k] = ins;
    in_rs1[k]   = r1;
    in_rs2[k]   = r2;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    a = alu_a[k];
    b = alu_b[k];
    c = alu_ctrl[k];
    lat = 0;
    while (!out_valid[k] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid[k]) begin
      errors++;
      $display("FAIL timeout dut%0d no out_valid after %0d cycles", k, lat);
    end
    res = out_result[k];
    err = out_err[k];
    rd  = out_rd[k];
    // New requests offered while the response is pending must be ignored.
    in_valid[k] = (hold > 0);
    in_instr[k] = 32'h002081b3;
    repeat (hold) @(posedge clk);
    #1;
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opc, f7;
    int sel;
    sel = $urandom_range(0, 9);
    opc = (sel < 4) ? 7'b0110011 : (sel < 8) ? 7'b0010011 : 7'($urandom);
    sel = $urandom_range(0, 5);
    f7  = (sel < 3) ? 7'b0000000 : (sel < 5) ? 7'b0100000 : 7'($urandom);
    return {f7, 5'($urandom), 5'($urandom), 3'($urandom), 5'($urandom), opc};
  endfunction

  logic [31:0] res, a, b;
  logic        err;
  logic [4:0]  rd;
  logic [2:0]  c;
  int          lat;

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_instr[k] = '0; in_rs1[k] = '0; in_rs2[k] = '0; out_ready[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", 0, in_ready[0], 1'b1);
    chk("reset out_valid", 1, out_valid[1], 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // add x3,x1,x2
    req(0, {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 32'd5, 32'd4, 0, res, err, rd, lat, a, b, c);
    chk("add ctrl", 0, c, 3'b000); chk("add a", 0, a, 32'd5); chk("add b", 0, b, 32'd4);
    chk("add lat", 0, lat, 1); chk("add res", 0, res, 32'd9); chk("add rd", 0, rd, 5'd3); chk("add err", 0, err, 1'b0);
    // sub
    req(0, {7'h20, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011}, 32'd36, -32'sd83, 0, res, err, rd, lat, a, b, c);
    chk("sub ctrl", 0, c, 3'b001); chk("sub res", 0, res, 32'd119);
    req(0, {7'h20, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011}, 32'd0, 32'd1, 1, res, err, rd, lat, a, b, c);
    chk("sub wrap", 0, res, 32'hFFFFFFFF);
    // srai / srli shamt 16
    req(0, {7'h20, 5'd16, 5'd1, 3'b101, 5'd4, 7'b0010011}, -32'sd400, 32'd0, 0, res, err, rd, lat, a, b, c);
    chk("srai ctrl", 0, c, 3'b111); chk("srai b", 0, b, 32'd16); chk("srai res", 0, res, 32'hFFFFFFFF);
    req(0, {7'h00, 5'd16, 5'd1, 3'b101, 5'd4, 7'b0010011}, -32'sd400, 32'd0, 0, res, err, rd, lat, a, b, c);
    chk("srli ctrl", 0, c, 3'b110); chk("srli res", 0, res, 32'h0000FFFF);
    // slt and a load opcode are illegal; ctrl stays at srli's value
    req(0, {7'h00, 5'd2, 5'd1, 3'b010, 5'd9, 7'b0110011}, 32'd1, 32'd2, 3, res, err, rd, lat, a, b, c);
    chk("slt lat", 0, lat, 0); chk("slt err", 0, err, 1'b1); chk("slt res", 0, res, 32'd0);
    chk("slt ctrl held", 0, c, 3'b110); chk("slt rd", 0, rd, 5'd9);
    req(0, {7'h00, 5'd2, 5'd1, 3'b000, 5'd10, 7'b0000011}, 32'd1, 32'd2, 0, res, err, rd, lat, a, b, c);
    chk("load err", 0, err, 1'b1); chk("load ctrl held", 0, c, 3'b110);
    // sll masks rs2 to 5 bits; addi sign-extends
    req(0, {7'h00, 5'd2, 5'd1, 3'b001, 5'd4, 7'b0110011}, 32'd1, 32'h26, 0, res, err, rd, lat, a, b, c);
    chk("sll b", 0, b, 32'd6); chk("sll res", 0, res, 32'd64);
    req(0, {12'hFFF, 5'd1, 3'b000, 5'd5, 7'b0010011}, 32'd10, 32'd0, 0, res, err, rd, lat, a, b, c);
    chk("addi b", 0, b, 32'hFFFFFFFF); chk("addi res", 0, res, 32'd9);

    // EXEC_CYCLES=3: async reset in the middle of EXEC
    in_valid[1] = 1'b1;
    in_instr[1] = {7'h20, 5'd2, 5'd1, 3'b000, 5'd8, 7'b0110011};
    in_rs1[1] = 32'd7; in_rs2[1] = 32'd8;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    chk("exec ctrl", 1, alu_ctrl[1], 3'b001);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst alu_a", 1, alu_a[1], 32'd0); chk("arst alu_b", 1, alu_b[1], 32'd0);
    chk("arst ctrl", 1, alu_ctrl[1], 3'd0); chk("arst out_valid", 1, out_valid[1], 1'b0);
    chk("arst out_rd", 1, out_rd[1], 5'd0); chk("arst in_ready", 1, in_ready[1], 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    req(1, {7'h20, 5'd2, 5'd1, 3'b000, 5'd8, 7'b0110011}, 32'd7, 32'd8, 2, res, err, rd, lat, a, b, c);
    chk("ec3 lat", 1, lat, 3); chk("ec3 res", 1, res, 32'hFFFFFFFF); chk("ec3 rd", 1, rd, 5'd8);

    // Randomized traffic on both instances, including requests offered while busy.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 2) != 0);
        in_instr[k]  = rand_instr();
        in_rs1[k]    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        in_rs2[k]    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        out_ready[k] = ($urandom_range(0, 2) != 0);
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b1;
    end
    repeat (10) @(posedge clk);
    #1;
    chk("drain in_ready", 0, in_ready[0], 1'b1);
    chk("drain in_ready", 1, in_ready[1], 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
